// File: rtl/reg_file_32x32_pkg.sv
// Shared constants and types for the 32-entry register file.
package reg_file_32x32_pkg;
    localparam int unsigned REG_COUNT      = 32;
    localparam int unsigned REG_ADDR_W     = 5;
    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned COUNT_W        = 16;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = '0;
endpackage

// File: rtl/reg_file_32x32_if.sv
// Write-back and read-port bundle between the datapath and the register file.
interface reg_file_32x32_if
    import reg_file_32x32_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) ();
    logic               RegWrite;
    reg_addr_t          WriteRegister;
    logic [DATA_W-1:0]  WriteData;
    reg_addr_t          ReadRegister1;
    reg_addr_t          ReadRegister2;
    logic [DATA_W-1:0]  ReadData1;
    logic [DATA_W-1:0]  ReadData2;
    logic [COUNT_W-1:0] WriteCount;

    modport master (
        output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
        input  ReadData1, ReadData2, WriteCount
    );

    modport slave (
        input  RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
        output ReadData1, ReadData2, WriteCount
    );
endinterface

// File: rtl/reg_file_bypass.sv
// Per-read-port forwarding: selects in-flight write data over the stored value on an index hit.
module reg_file_bypass
    import reg_file_32x32_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter bit          BYPASS = 1'b1
) (
    input  logic              fwd_en_i,
    input  reg_addr_t         waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  reg_addr_t         raddr_i,
    input  logic [DATA_W-1:0] stored_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic hit;

    assign hit     = fwd_en_i && (raddr_i == waddr_i);
    assign rdata_o = (BYPASS && hit) ? wdata_i : stored_i;
endmodule

// File: rtl/reg_file_32x32.sv
// 32 x DATA_W register file, two combinational read ports, one write port, write counter.
module reg_file_32x32
    import reg_file_32x32_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter bit          BYPASS = 1'b1
) (
    input logic             clk,
    input logic             rst_n,
    reg_file_32x32_if.slave bus
);
    logic [DATA_W-1:0]  regs_q [REG_COUNT];
    logic [COUNT_W-1:0] count_q;
    logic               we;
    logic               fwd_en;
    logic [DATA_W-1:0]  stored1;
    logic [DATA_W-1:0]  stored2;

    assign we = bus.RegWrite && (bus.WriteRegister != ZERO_REG);

    // Forwarding is gated by reset so every index reads 0 while rst_n is low.
    assign fwd_en = we && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
            count_q <= '0;
        end else if (we) begin
            regs_q[bus.WriteRegister] <= bus.WriteData;
            count_q                   <= count_q + 1'b1;
        end
    end

    assign stored1 = (bus.ReadRegister1 == ZERO_REG) ? '0 : regs_q[bus.ReadRegister1];
    assign stored2 = (bus.ReadRegister2 == ZERO_REG) ? '0 : regs_q[bus.ReadRegister2];

    reg_file_bypass #(
        .DATA_W (DATA_W),
        .BYPASS (BYPASS)
    ) u_bypass1 (
        .fwd_en_i (fwd_en),
        .waddr_i  (bus.WriteRegister),
        .wdata_i  (bus.WriteData),
        .raddr_i  (bus.ReadRegister1),
        .stored_i (stored1),
        .rdata_o  (bus.ReadData1)
    );

    reg_file_bypass #(
        .DATA_W (DATA_W),
        .BYPASS (BYPASS)
    ) u_bypass2 (
        .fwd_en_i (fwd_en),
        .waddr_i  (bus.WriteRegister),
        .wdata_i  (bus.WriteData),
        .raddr_i  (bus.ReadRegister2),
        .stored_i (stored2),
        .rdata_o  (bus.ReadData2)
    );

    assign bus.WriteCount = count_q;
endmodule
